// File: rtl/ita_scan_decoder_if.sv
// Bus between the 12-digit scan source / frame reader and ita_scan_decoder.
// The master drives the scan inputs and read address; the slave returns frame status.
interface ita_scan_decoder_if;
  logic [11:0] sel;
  logic [13:0] segm;
  logic [3:0]  rd_addr;
  logic [3:0]  rd_code;
  logic        frame_done;
  logic        frame_valid;
  logic        match;
  logic        sync_err;
  logic        glyph_err;
  logic [7:0]  err_count;

  modport master (
    output sel, segm, rd_addr,
    input  rd_code, frame_done, frame_valid, match, sync_err, glyph_err, err_count
  );

  modport slave (
    input  sel, segm, rd_addr,
    output rd_code, frame_done, frame_valid, match, sync_err, glyph_err, err_count
  );
endinterface

// File: rtl/ita_scan_decoder.sv
// Locks onto a multiplexed 12-digit 14-segment scan, decodes each digit to a glyph
// code and commits complete, in-order frames to a readable buffer.
module ita_scan_decoder (
`ifdef USE_POWER_PINS
  inout wire vdd,
  inout wire vss,
`endif
  input  logic              clk,
  input  logic              rst,
  ita_scan_decoder_if.slave bus
);

  typedef enum logic [0:0] {ST_HUNT = 1'b0, ST_CAPTURE = 1'b1} state_t;

  localparam logic [3:0] C_BAD = 4'hF;
  // "ING ELEC ITA", slot 11 first
  localparam logic [11:0][3:0] C_TEXT = {4'h1, 4'h8, 4'h5, 4'h0, 4'h2, 4'h3,
                                         4'h6, 4'h3, 4'h0, 4'h4, 4'h7, 4'h5};

  function automatic logic [3:0] decode_glyph(input logic [13:0] seg);
    case (seg)
      14'b00000000000000: decode_glyph = 4'h0;
      14'b11101111000000: decode_glyph = 4'h1;
      14'b10011100000000: decode_glyph = 4'h2;
      14'b10011110000000: decode_glyph = 4'h3;
      14'b10111101000000: decode_glyph = 4'h4;
      14'b10010000010010: decode_glyph = 4'h5;
      14'b00011100000000: decode_glyph = 4'h6;
      14'b01101100100100: decode_glyph = 4'h7;
      14'b10000000010010: decode_glyph = 4'h8;
      default:            decode_glyph = C_BAD;
    endcase
  endfunction

  function automatic logic [11:0] digit_hot(input logic [3:0] idx);
    digit_hot = 12'd1 << idx;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_exp, w_exp_nxt;
  logic [11:0]      r_sel;
  logic [13:0]      r_segm;
  logic [11:0][3:0] r_cap, r_com, w_frame;
  logic [3:0]       w_code, w_slot, w_last;
  logic [11:0]      w_exp_hot, w_last_hot;
  logic             w_write, w_commit, w_sync_err, w_glyph_err;
  logic             r_frame_done, r_frame_valid, r_match, r_sync_err, r_glyph_err;
  logic [3:0]       r_rd_code;
  logic [7:0]       r_err_count;

  assign w_code      = decode_glyph(r_segm);
  assign w_last      = (r_exp == 4'd0) ? 4'd11 : r_exp - 4'd1;
  assign w_exp_hot   = digit_hot(r_exp);
  assign w_last_hot  = digit_hot(w_last);
  assign w_commit    = w_write && (w_slot == 4'd11);
  assign w_glyph_err = w_write && (w_code == C_BAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= 12'd0;
      r_segm <= 14'd0;
    end else begin
      r_sel  <= bus.sel;
      r_segm <= bus.segm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HUNT;
      r_exp   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  // A repeat of the last accepted digit is a slow scan, not an error.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    case (r_state)
      ST_HUNT: begin
        if (r_sel == 12'd1) begin
          w_state_nxt = ST_CAPTURE;
          w_exp_nxt   = 4'd1;
        end else begin
          w_state_nxt = ST_HUNT;
        end
      end
      ST_CAPTURE: begin
        if (r_sel == 12'd0) begin
          w_state_nxt = ST_CAPTURE;
        end else if (r_sel == w_exp_hot) begin
          w_exp_nxt = (r_exp == 4'd11) ? 4'd0 : r_exp + 4'd1;
        end else if (r_sel == w_last_hot) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_state_nxt = ST_HUNT;
          w_exp_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_exp_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_write    = 1'b0;
    w_slot     = 4'd0;
    w_sync_err = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (r_sel == 12'd1) begin
          w_write = 1'b1;
        end else begin
          w_write = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (r_sel == 12'd0) begin
          w_write = 1'b0;
        end else if (r_sel == w_exp_hot) begin
          w_write = 1'b1;
          w_slot  = r_exp;
        end else if (r_sel == w_last_hot) begin
          w_write = 1'b0;
        end else begin
          w_sync_err = 1'b1;
        end
      end
      default: begin
        w_write = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_frame     = r_cap;
    w_frame[11] = w_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap         <= '0;
      r_com         <= '0;
      r_rd_code     <= 4'h0;
      r_frame_done  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_match       <= 1'b0;
      r_sync_err    <= 1'b0;
      r_glyph_err   <= 1'b0;
      r_err_count   <= 8'd0;
    end else begin
      r_frame_done <= w_commit;
      r_sync_err   <= w_sync_err;
      r_glyph_err  <= w_glyph_err;
      if (w_sync_err) begin
        r_cap <= '0;
        if (r_err_count != 8'hFF) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end else if (w_write) begin
        r_cap[w_slot] <= w_code;
      end
      // Whole frame lands at once, so readers never see a mix of two frames.
      if (w_commit) begin
        r_com         <= w_frame;
        r_frame_valid <= 1'b1;
        r_match       <= (w_frame == C_TEXT);
      end
      r_rd_code <= (bus.rd_addr < 4'd12) ? r_com[bus.rd_addr] : C_BAD;
    end
  end

  assign bus.rd_code     = r_rd_code;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_valid = r_frame_valid;
  assign bus.match       = r_match;
  assign bus.sync_err    = r_sync_err;
  assign bus.glyph_err   = r_glyph_err;
  assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_ita_scan_decoder.sv
// Self-checking bench for ita_scan_decoder: pulse outputs tracked by a two-deep
// scoreboard, frame contents checked through table-driven read-back.
module tb_ita_scan_decoder;

  typedef struct {
    logic fd;
    logic se;
    logic ge;
  } pulse_t;

  typedef struct {
    logic [13:0] segm;
    logic [3:0]  code;
    logic        bad;
  } glyph_vec_t;

  localparam logic [13:0] S_SP = 14'b00000000000000;
  localparam logic [13:0] S_A  = 14'b11101111000000;
  localparam logic [13:0] S_C  = 14'b10011100000000;
  localparam logic [13:0] S_E  = 14'b10011110000000;
  localparam logic [13:0] S_G  = 14'b10111101000000;
  localparam logic [13:0] S_I  = 14'b10010000010010;
  localparam logic [13:0] S_L  = 14'b00011100000000;
  localparam logic [13:0] S_N  = 14'b01101100100100;
  localparam logic [13:0] S_T  = 14'b10000000010010;

  logic clk;
  logic rst;
  ita_scan_decoder_if bus ();

  ita_scan_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_err  = 0;
  pulse_t      sb[$];
  logic [13:0] cur_seg[12];
  logic        cur_bad[12];
  logic [3:0]  exp_code[12];
  glyph_vec_t  gv[12];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] hot(input int d);
    hot = 12'd1 << d;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: check pulses due from two drives ago, then apply new inputs.
  task automatic drive(input logic [11:0] s, input logic [13:0] g,
                       input logic fd, input logic se, input logic ge);
    pulse_t e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      chk("pulses{frame_done,sync_err,glyph_err}",
          {13'd0, bus.frame_done, bus.sync_err, bus.glyph_err}, {13'd0, e.fd, e.se, e.ge});
    end
    bus.sel  = s;
    bus.segm = g;
    e.fd = fd;
    e.se = se;
    e.ge = ge;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(12'd0, 14'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scan(input int first, input int last, input int hold, input bit aligned);
    for (int d = first; d <= last; d++) begin
      for (int h = 0; h < hold; h++) begin
        drive(hot(d), cur_seg[d], aligned && h == 0 && d == 11, 1'b0,
              aligned && h == 0 && cur_bad[d]);
      end
    end
  endtask

  task automatic do_reset(input int n);
    idle();
    rst = 1'b1;
    repeat (n) idle();
    rst = 1'b0;
    exp_err = 0;
    chk("reset rd_code", {12'd0, bus.rd_code}, 16'h0000);
    chk("reset frame_valid", {15'd0, bus.frame_valid}, 16'h0000);
    chk("reset match", {15'd0, bus.match}, 16'h0000);
    chk("reset err_count", {8'd0, bus.err_count}, 16'h0000);
  endtask

  task automatic levels(input logic valid, input logic mt);
    chk("frame_valid", {15'd0, bus.frame_valid}, {15'd0, valid});
    chk("match", {15'd0, bus.match}, {15'd0, mt});
    chk("err_count", {8'd0, bus.err_count}, exp_err[15:0]);
  endtask

  task automatic rd_all();
    idle();
    idle();
    for (int a = 0; a < 16; a++) begin
      bus.rd_addr = a[3:0];
      idle();
      chk($sformatf("rd_code[%0d]", a), {12'd0, bus.rd_code},
          {12'd0, (a < 12) ? exp_code[a] : 4'hF});
    end
    bus.rd_addr = 4'd0;
  endtask

  task automatic load_text();
    cur_seg  = '{S_I, S_N, S_G, S_SP, S_E, S_L, S_E, S_C, S_SP, S_I, S_T, S_A};
    exp_code = '{4'h5, 4'h7, 4'h4, 4'h0, 4'h3, 4'h6, 4'h3, 4'h2, 4'h0, 4'h5, 4'h8, 4'h1};
    for (int i = 0; i < 12; i++) cur_bad[i] = 1'b0;
  endtask

  initial begin
    gv[0]  = '{S_SP, 4'h0, 1'b0};
    gv[1]  = '{S_A,  4'h1, 1'b0};
    gv[2]  = '{S_C,  4'h2, 1'b0};
    gv[3]  = '{S_E,  4'h3, 1'b0};
    gv[4]  = '{S_G,  4'h4, 1'b0};
    gv[5]  = '{S_I,  4'h5, 1'b0};
    gv[6]  = '{S_L,  4'h6, 1'b0};
    gv[7]  = '{S_N,  4'h7, 1'b0};
    gv[8]  = '{S_T,  4'h8, 1'b0};
    gv[9]  = '{14'h3FFF, 4'hF, 1'b1};
    gv[10] = '{14'b00000000000001, 4'hF, 1'b1};
    gv[11] = '{14'b11101111000001, 4'hF, 1'b1};

    rst = 1'b1;
    bus.sel = 12'd0;
    bus.segm = 14'd0;
    bus.rd_addr = 4'd0;
    do_reset(3);

    // Aligned text scan, two back-to-back frames
    load_text();
    scan(0, 11, 1, 1);
    scan(0, 11, 1, 1);
    rd_all();
    levels(1'b1, 1'b1);

    // Scan begins mid-frame: nothing commits until digit 0 is seen
    do_reset(2);
    scan(5, 11, 1, 0);
    idle();
    idle();
    levels(1'b0, 1'b0);
    scan(0, 11, 1, 1);
    idle();
    idle();
    levels(1'b1, 1'b1);

    // Digit 7 skipped: one sync_err, committed text untouched, realign at 0
    for (int i = 0; i < 12; i++) cur_seg[i] = S_SP;
    scan(0, 6, 1, 1);
    drive(hot(8), S_SP, 1'b0, 1'b1, 1'b0);
    exp_err++;
    load_text();
    scan(9, 11, 1, 0);
    rd_all();
    levels(1'b1, 1'b1);
    scan(0, 11, 1, 1);

    // Two-bit select in CAPTURE, repeated until err_count saturates
    for (int i = 0; i < 300; i++) begin
      drive(hot(0), S_I, 1'b0, 1'b0, 1'b0);
      drive(12'b000000000011, S_I, 1'b0, 1'b1, 1'b0);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      if (i == 4) begin
        idle();
        idle();
        levels(1'b1, 1'b1);
      end
    end
    idle();
    idle();
    chk("err_count saturated", {8'd0, bus.err_count}, 16'd255);

    // Bad glyph on digit 2, every digit held three cycles
    load_text();
    cur_seg[2]  = 14'h3FFF;
    cur_bad[2]  = 1'b1;
    exp_code[2] = 4'hF;
    scan(0, 11, 3, 1);
    scan(0, 11, 3, 1);
    rd_all();
    levels(1'b1, 1'b0);

    // Table of every glyph plus unrecognised patterns
    for (int i = 0; i < 12; i++) begin
      cur_seg[i]  = gv[i].segm;
      cur_bad[i]  = gv[i].bad;
      exp_code[i] = gv[i].code;
    end
    scan(0, 11, 1, 1);
    rd_all();
    levels(1'b1, 1'b0);

    // Reset lands during digit 6, then a clean frame
    load_text();
    scan(0, 5, 1, 1);
    drive(hot(6), S_E, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    scan(0, 11, 1, 1);
    rd_all();
    levels(1'b1, 1'b1);

    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
